// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-file target.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package i2c_target_pkg;

    localparam int BYTE_W = 8;

    // SDA level seen on the ninth bit: low acknowledges, high refuses.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one open-drain bus line, rejects glitches shorter than FILT_LEN clk, flags edges.
// Latency: 2 + FILT_LEN clk from pad change to level/rise/fall.
// Backpressure: none; free-running sampler.
module i2c_line_filter
    import i2c_target_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The FILT_LEN-th consecutive sample that differs from the held level flips it.
    assign accept = (sync_b != level) && (cnt == CNT_LAST);

    // Two-flop synchronizer; an idle I2C line rests high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= line_in;
            sync_b <= sync_a;
        end
    end

    // Glitch filter: count differing samples, restart the count on any agreeing sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= accept & sync_b;
            fall <= accept & ~sync_b;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an 8-bit register pointer and a byte register file (Versaclock-style map).
// Latency: bus events act 2 + FILT_LEN clk after the pad edge; writes land on the 8th SCL rise.
// Backpressure: none; SCL is never stretched, the master alone paces the bus.
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h6A,
    parameter int         NUM_REGS = 32,
    parameter int         FILT_LEN = 4,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scl_in,
    input  logic                       sda_in,
    output logic                       scl_oe,
    output logic                       sda_oe,
    output logic [NUM_REGS*BYTE_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [BYTE_W-1:0]          wr_addr,
    output logic [BYTE_W-1:0]          wr_data,
    output logic                       busy
);

    localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NREGS_9 = 9'(NUM_REGS);

    logic [BYTE_W-1:0] regs [NUM_REGS];
    state_t            state;
    logic [3:0]        bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic [BYTE_W-1:0] ptr;
    logic              rw;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;
    logic in_range;
    logic [BYTE_W-1:0] ptr_next;
    logic [BYTE_W-1:0] rd_byte;
    logic [BYTE_W-1:0] shift_in;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk),
        .reset   (reset),
        .line_in (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk),
        .reset   (reset),
        .line_in (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    // SDA moving while SCL is high frames a transfer.
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    // Pointer may be loaded beyond the map; such accesses read 0 and drop writes.
    assign in_range = {1'b0, ptr} < NREGS_9;
    assign ptr_next = ({1'b0, ptr} == NREGS_9 - 9'd1) ? '0 : ptr + 8'd1;
    assign rd_byte  = in_range ? regs[ptr[IDX_W-1:0]] : '0;
    assign shift_in = {shreg[6:0], sda_lvl};

    assign scl_oe = 1'b0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[BYTE_W*g +: BYTE_W] = regs[g];
    end

    // Protocol FSM: START/STOP pre-empt any bit edge, data is sampled on SCL rise,
    // SDA drive only changes on SCL fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                // Repeated START lands here too; the pointer is deliberately kept.
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shreg[7:1] == I2C_ADDR) begin
                                rw     <= shreg[0];
                                sda_oe <= 1'b1;
                                state  <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                // The ACK falling edge also presents the first read bit.
                                shreg   <= {rd_byte[6:0], 1'b0};
                                sda_oe  <= ~rd_byte[7];
                                bit_cnt <= 4'd1;
                                state   <= ST_RD_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr    <= shreg;
                            sda_oe <= 1'b1;
                            state  <= ST_PTR_ACK;
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (in_range) begin
                                    regs[ptr[IDX_W-1:0]] <= shift_in;
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= shift_in;
                                end
                                ptr <= ptr_next;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= ST_WR_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RD_ACK;
                            end else begin
                                sda_oe  <= ~shreg[7];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // Every byte handed to the master advances the pointer, even the
                        // NACKed last one, so a follow-up read resumes after it.
                        if (scl_rise) begin
                            ptr <= ptr_next;
                            if (sda_lvl != ACK) state <= ST_WAIT_STOP;
                        end else if (scl_fall) begin
                            shreg   <= {rd_byte[6:0], 1'b0};
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= 4'd1;
                            state   <= ST_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
I2C target (responder) that answers the I2C master driving I2C_IDT_SCL/I2C_IDT_SDA. It emulates a Versaclock-style register-mapped device: an 8-bit register pointer plus an internal byte register file. Used for on-board loopback bring-up of the master and as a synthesizable bench responder. Open-drain style: the block drives only output-enables; the top level converts oe into a pulled-low/tri-state pad.

Parameters:
I2C_ADDR, 7'h6A, 7-bit target address matched against the address byte
NUM_REGS, 32, register count, power of 2 from 2 to 256
FILT_LEN, 4, consecutive equal clk samples required to accept a new SCL/SDA level
RST_VAL, 0, byte reset value of every register

Ports:
clk  in  1  system clock, 125 MHz
reset  in  1  asynchronous, active-high reset
scl_in  in  1  SCL pad level, asynchronous
sda_in  in  1  SDA pad level, asynchronous
scl_oe  out  1  SCL pull-low enable; constant 0 (no clock stretching)
sda_oe  out  1  SDA pull-low enable (1 = drive 0)
regs_out  out  NUM_REGS*8  flattened register file, reg i at [8i+7:8i]
wr_strobe  out  1  one-cycle pulse per accepted write byte
wr_addr  out  8  register index of the last write
wr_data  out  8  data of the last write
busy  out  1  high from START to STOP

Behaviour:
- Reset (async): all outputs 0, regs = RST_VAL, pointer 0, state IDLE. Reset mid-transfer releases SDA immediately.
- Input path: 2-flop synchronizer, then a glitch filter. A level change is accepted only after FILT_LEN equal samples. Edge detects use the filtered levels. Latency from pad to filtered level: 2+FILT_LEN clk.
- START = filtered SDA falls while SCL high. STOP = SDA rises while SCL high. Both are detected in every state.
- START: go to ADDR, clear bit count, set busy. Repeated START behaves the same and keeps the pointer.
- STOP: go to IDLE, release sda_oe in the same cycle, clear busy.
- Bit timing: sample SDA on each filtered SCL rising edge. Change sda_oe only on filtered SCL falling edges.
- ADDR: shift 8 bits MSB first.
  - Addr[7:1] == I2C_ADDR: go to ADDR_ACK and drive sda_oe=1 from the 8th falling edge to the 9th falling edge.
  - Mismatch: do not drive; go to WAIT_STOP (ignore bus until START/STOP).
  - After ACK: R/W=0 goes to PTR; R/W=1 goes to RD_DATA.
- PTR: shift 8 bits, load pointer, ACK, go to WR_DATA.
- WR_DATA: shift 8 bits, then always ACK.
  - On the 8th rising edge, if pointer < NUM_REGS: write regs[pointer], pulse wr_strobe for 1 clk, update wr_addr/wr_data.
  - If pointer >= NUM_REGS: write ignored, no strobe.
  - Then pointer++.
- RD_DATA:
  - At the ACK falling edge, load the shift register with regs[pointer], or 8'h00 if out of range.
  - Drive sda_oe = ~bit on each falling edge, MSB first. Release at the 8th falling edge.
  - Sample master ACK on the 9th rising edge.
  - ACK (SDA=0): pointer++, continue in RD_DATA.
  - NACK: go to WAIT_STOP.
- Pointer: 8-bit, increments modulo NUM_REGS (NUM_REGS-1 wraps to 0). At NUM_REGS=256 it wraps naturally.
- Simultaneous START/STOP and bit edge: START/STOP wins; the partial byte is discarded with no write.
- scl_oe tied 0. No general-call or 10-bit address support.

Decomposition:
- Package i2c_target_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP)
  - BYTE_W=8
  - ACK/NACK level constants
- Sub-module i2c_line_filter: sync + glitch filter + rise/fall pulses. Parameter FILT_LEN. Instantiated once for SCL and once for SDA.

Test Plan:
1. Write to 0x6A: pointer 0x05, data 0xA5, 0x3C, STOP -> three ACKs; regs[5]=A5, regs[6]=3C; two wr_strobe pulses with wr_addr 05/06; busy low after STOP.
2. Address 0x50 write -> SDA never driven (NACK); no wr_strobe; regs unchanged; next START to 0x6A is accepted.
3. Write pointer 0x05, repeated START, read 2 bytes (ACK then NACK) -> master receives A5, 3C; sda_oe released after the NACK; pointer = 7.
4. Pointer 0x1F, write 0x11, 0x22 -> regs[31]=11, regs[0]=22 (wrap). Read from 0x1F for 2 bytes -> 11, 22.
5. 2-clk low glitch on SCL while high and a 3-clk SDA pulse (FILT_LEN=4) -> no bit shifted, no false START/STOP, transfer completes correctly.
6. STOP after 4 data bits, then reset asserted mid-read of 0xA5 -> no write from the partial byte; reset drops sda_oe to 0 immediately; regs return to 0.
